lfsr_gen: RTL

//   Parametrised LFSR pseudo-random generator: successor to the fixed 4-bit shifter.

---
 rtl/lfsr_pkg.sv | 57 +++++
 rtl/lfsr_next_state.sv | 24 ++
 rtl/lfsr_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - LFSR mode constants and maximal-length tap table
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    localparam int unsigned LFSR_MIN_WIDTH = 3;
    localparam int unsigned LFSR_MAX_WIDTH = 32;

    // Fibonacci mask sets bit k-1 for each term x^k of a primitive polynomial;
    // the Galois mask for the same polynomial is that shifted up one plus x^0.
    function automatic logic [31:0] lfsr_max_taps(input int unsigned width, input lfsr_mode_e mode);
        logic [31:0] fib;
        logic [31:0] mask;
        case (width)
            3:       fib = 32'h0000_0006;
            4:       fib = 32'h0000_000C;
            5:       fib = 32'h0000_0014;
            6:       fib = 32'h0000_0030;
            7:       fib = 32'h0000_0060;
            8:       fib = 32'h0000_00B8;
            9:       fib = 32'h0000_0110;
            10:      fib = 32'h0000_0240;
            11:      fib = 32'h0000_0500;
            12:      fib = 32'h0000_0829;
            13:      fib = 32'h0000_100D;
            14:      fib = 32'h0000_2015;
            15:      fib = 32'h0000_6000;
            16:      fib = 32'h0000_D008;
            17:      fib = 32'h0001_2000;
            18:      fib = 32'h0002_0400;
            19:      fib = 32'h0004_0023;
            20:      fib = 32'h0009_0000;
            21:      fib = 32'h0014_0000;
            22:      fib = 32'h0030_0000;
            23:      fib = 32'h0042_0000;
            24:      fib = 32'h00E1_0000;
            25:      fib = 32'h0120_0000;
            26:      fib = 32'h0200_0023;
            27:      fib = 32'h0400_0013;
            28:      fib = 32'h0900_0000;
            29:      fib = 32'h1400_0000;
            30:      fib = 32'h2000_0029;
            31:      fib = 32'h4800_0000;
            32:      fib = 32'h8020_0003;
            default: fib = 32'h0000_0000;
        endcase
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (mode == LFSR_GAL) begin
            return ((fib << 1) | 32'd1) & mask;
        end
        return fib;
    endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// rtl/lfsr_next_state.sv - combinational LFSR successor for Fibonacci or Galois form
module lfsr_next_state
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100)
) (
    input  logic [WIDTH-1:0] q,
    input  lfsr_mode_e       mode,
    output logic [WIDTH-1:0] q_next
);

    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;

    always_comb begin
        fib_fb   = ^(q & TAPS);
        fib_next = {q[WIDTH-2:0], fib_fb};
        gal_next = {q[WIDTH-2:0], 1'b0} ^ ({WIDTH{q[WIDTH-1]}} & TAPS);
        q_next   = (mode == LFSR_GAL) ? gal_next : fib_next;
    end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised LFSR generator with seed load, lockup recovery and period measurement
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 4,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(4'b1100),
    parameter bit               GALOIS = 1'b0,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lock_err
);

    if (SEED == '0) begin : g_seed_chk
        $error("lfsr_gen: SEED must be nonzero");
    end
    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_width_chk
        $error("lfsr_gen: WIDTH out of range");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             lock_err_q, lock_err_d;
    logic [WIDTH-1:0] step_q;

    lfsr_next_state #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .q      (q_q),
        .mode   (lfsr_mode_e'(GALOIS)),
        .q_next (step_q)
    );

    always_comb begin
        q_d        = q_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        wrap_d     = 1'b0;
        lock_err_d = 1'b0;
        if (load) begin
            cnt_d = '0;
            if (seed_in != '0) begin
                q_d     = seed_in;
                start_d = seed_in;
            end else begin
                q_d        = SEED;
                start_d    = SEED;
                lock_err_d = 1'b1;
            end
        end else if (en) begin
            // All-zero state is a fixed point of both forms, so recover instead of stepping.
            if (q_q == '0) begin
                q_d        = SEED;
                start_d    = SEED;
                cnt_d      = '0;
                lock_err_d = 1'b1;
            end else begin
                q_d = step_q;
                if (step_q == start_q) begin
                    period_d = cnt_q + WIDTH'(1);
                    cnt_d    = '0;
                    wrap_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= SEED;
            start_q    <= SEED;
            cnt_q      <= '0;
            period_q   <= '0;
            wrap_q     <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            wrap_q     <= wrap_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign q        = q_q;
    assign bit_out  = q_q[WIDTH-1];
    assign wrap     = wrap_q;
    assign period   = period_q;
    assign lock_err = lock_err_q;

endmodule
